truth_table_sweeper: RTL and testbench

- Stimulus/capture engine for 3-input combinational lab functions. It is the driving side of a function block: it generates inputs and reads back the output.
- Steps stim through every input code 0..2^N_IN-1, waits a settle interval, then samples resp into a truth-table register.
- Compares the finished table to an expected constant and reports pass, mismatch count and first failing index.
- Sits between board switches/buttons (start, abort) and the combinational function under test; results go to LEDs/7-seg.

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_compare.sv | 33 +++
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 tb/tb_truth_table_sweeper.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweeper.
package tt_pkg;

  localparam int DEFAULT_N_IN = 3;
  localparam int TBL_W = 2 ** DEFAULT_N_IN;
  localparam logic [TBL_W-1:0] EXPECTED_DEFAULT = 8'h57;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/tt_compare.sv
// Combinational grading of a captured truth table against the golden table.
module tt_compare #(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
  input  logic [2**N_IN-1:0] work,
  output logic               pass,
  output logic [N_IN:0]      mismatch_cnt,
  output logic [N_IN-1:0]    first_fail
);

  logic [2**N_IN-1:0] diff;
  logic               found;

  // Popcount of the difference plus a priority encoder favouring the lowest index.
  always_comb begin
    diff         = work ^ EXPECTED;
    pass         = (diff == '0);
    mismatch_cnt = '0;
    first_fail   = '0;
    found        = 1'b0;
    for (int i = 0; i < 2**N_IN; i++) begin
      if (diff[i]) begin
        mismatch_cnt = mismatch_cnt + (N_IN+1)'(1);
        if (!found) begin
          first_fail = N_IN'(i);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input code to a combinational function, captures its output, grades the table.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2**N_IN-1:0]  work;
  logic                cmp_pass;
  logic [N_IN:0]       cmp_cnt;
  logic [N_IN-1:0]     cmp_first;

  tt_compare #(
    .N_IN     (N_IN),
    .EXPECTED (EXPECTED)
  ) u_compare (
    .work         (work),
    .pass         (cmp_pass),
    .mismatch_cnt (cmp_cnt),
    .first_fail   (cmp_first)
  );

  // Abort is only honoured once a sweep is running; results are kept on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      first_fail   <= '0;
      work         <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            stim  <= '0;
            cnt   <= '0;
            work  <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
          end else begin
            work[stim] <= resp;
            if (stim == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              stim  <= stim + N_IN'(1);
              cnt   <= '0;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          stim  <= '0;
          if (!abort) begin
            table_out    <= work;
            pass         <= cmp_pass;
            mismatch_cnt <= cmp_cnt;
            first_fail   <= cmp_first;
          end
        end
        default: begin
          state <= IDLE;
          stim  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: three sweeper instances (settle 2, 1, 4) driven by a modelled lab function.
module tb_truth_table_sweeper;

  typedef struct {
    int         mode;
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] cnt;
    logic [2:0] ff;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort;
  int   mode;
  int   which;
  logic start2, start1, start4;

  logic [2:0] stim2, stim1, stim4;
  logic       resp2, resp1, resp4;
  logic       busy2, busy1, busy4;
  logic       done2, done1, done4;
  logic [7:0] table2, table1, table4;
  logic       pass2, pass1, pass4;
  logic [3:0] cnt2, cnt1, cnt4;
  logic [2:0] ff2, ff1, ff4;

  logic [2:0] s_stim;
  logic       s_busy, s_done, s_pass;
  logic [7:0] s_table;
  logic [3:0] s_cnt;
  logic [2:0] s_ff;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t vec[3];

  // Modelled function under test: 0 = correct, 1 = faulty ~c, other = stuck at 1.
  function automatic logic lab_fn(input int m, input logic [2:0] s);
    case (m)
      0:       return (~s[2] & ~s[1]) | ~s[0];
      1:       return ~s[0];
      default: return 1'b1;
    endcase
  endfunction

  assign resp2 = lab_fn(mode, stim2);
  assign resp1 = lab_fn(mode, stim1);
  assign resp4 = lab_fn(mode, stim4);

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2), .EXPECTED(8'h57)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .table_out(table2), .pass(pass2),
    .mismatch_cnt(cnt2), .first_fail(ff2));

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h57)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .table_out(table1), .pass(pass1),
    .mismatch_cnt(cnt1), .first_fail(ff1));

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4), .EXPECTED(8'h57)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .stim(stim4), .resp(resp4),
    .busy(busy4), .done(done4), .table_out(table4), .pass(pass4),
    .mismatch_cnt(cnt4), .first_fail(ff4));

  always_comb begin
    s_stim = stim2; s_busy = busy2; s_done = done2; s_table = table2;
    s_pass = pass2; s_cnt = cnt2; s_ff = ff2;
    if (which == 1) begin
      s_stim = stim1; s_busy = busy1; s_done = done1; s_table = table1;
      s_pass = pass1; s_cnt = cnt1; s_ff = ff1;
    end else if (which == 4) begin
      s_stim = stim4; s_busy = busy4; s_done = done4; s_table = table4;
      s_pass = pass4; s_cnt = cnt4; s_ff = ff4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start(input int w);
    @(negedge clk);
    case (w)
      1:       start1 = 1'b1;
      4:       start4 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic applyStimulus(input int w, input exp_t e);
    which = w;
    mode  = e.mode;
    sb.push_back(e);
    pulse_start(w);
  endtask

  // Counts edges from the accepting edge, checks stim stepping, done timing and the graded result.
  task automatic checkOutput(input int settle, input logic [7:0] prev_tbl);
    int   e;
    exp_t x;
    e = 0;
    while (e < 400) begin
      @(negedge clk);
      if (s_done) break;
      if (e < 8 * (settle + 1)) check("stim_step", 32'(s_stim), 32'(e / (settle + 1)));
      @(posedge clk);
      e++;
    end
    check("done_edge", 32'(e), 32'(8 * (settle + 1)));
    check("table_before_done_edge", 32'(s_table), 32'(prev_tbl));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(s_done), 32'd0);
    check("table_out", 32'(s_table), 32'(x.tbl));
    check("pass", 32'(s_pass), 32'(x.pass));
    check("mismatch_cnt", 32'(s_cnt), 32'(x.cnt));
    check("first_fail", 32'(s_ff), 32'(x.ff));
    check("stim_idle", 32'(s_stim), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         done_seen;
    logic [7:0] prev;

    vec[0] = '{mode: 0, tbl: 8'h57, pass: 1'b1, cnt: 4'd0, ff: 3'd0};
    vec[1] = '{mode: 1, tbl: 8'h55, pass: 1'b0, cnt: 4'd1, ff: 3'd1};
    vec[2] = '{mode: 2, tbl: 8'hFF, pass: 1'b0, cnt: 4'd3, ff: 3'd3};

    rst_n = 1'b0; abort = 1'b0; mode = 0; which = 2;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    #12;
    check("reset_stim", 32'(stim2), 32'd0);
    check("reset_busy", 32'(busy2), 32'd0);
    check("reset_done", 32'(done2), 32'd0);
    check("reset_table", 32'(table2), 32'd0);
    check("reset_pass", 32'(pass2), 32'd0);
    check("reset_cnt_ff", 32'({cnt2, ff2}), 32'd0);
    #10 rst_n = 1'b1;

    // Graded sweeps: correct, faulty ~c, stuck-at-1, then correct again over a stale table.
    prev = 8'h00;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, vec[i]);
      checkOutput(2, prev);
      prev = vec[i].tbl;
    end
    applyStimulus(2, vec[0]);
    checkOutput(2, prev);
    prev = 8'h57;

    // Abort on the tenth edge of a stuck-at-1 sweep must leave the good result untouched.
    which = 2; mode = 2;
    pulse_start(2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy2), 32'd0);
    check("abort_stim", 32'(stim2), 32'd0);
    check("abort_table", 32'(table2), 32'h57);
    check("abort_pass", 32'(pass2), 32'd1);
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done2 || busy2) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    applyStimulus(2, vec[0]);
    checkOutput(2, prev);

    // Extra starts while busy or in DONE are ignored.
    mode = 0;
    pulse_start(2);
    done_seen = 0;
    for (int e = 1; e < 60; e++) begin
      @(negedge clk);
      start2 = (e == 3 || e == 8 || e == 15 || e == 22 || e == 24);
      if (done2) done_seen++;
      @(posedge clk);
      #1;
      start2 = 1'b0;
    end
    check("one_done_per_start", 32'(done_seen), 32'd1);
    check("idle_after_restarts", 32'(busy2), 32'd0);

    // Reset mid-sweep clears everything before the next clock edge.
    pulse_start(2);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy2), 32'd0);
    check("rst_mid_stim", 32'(stim2), 32'd0);
    check("rst_mid_table", 32'(table2), 32'd0);
    check("rst_mid_pass", 32'(pass2), 32'd0);
    check("rst_mid_cnt_ff", 32'({cnt2, ff2, done2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Alternate settle intervals.
    applyStimulus(1, vec[0]);
    checkOutput(1, 8'h00);
    applyStimulus(4, vec[1]);
    checkOutput(4, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
